// File: rtl/mem_bus_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_responder_pkg
// Purpose  : Size encodings and FSM state type shared by the memory responder.
// Revision : 1.0 - initial release
// ============================================================================
package mem_bus_responder_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_lane_format.sv
`default_nettype none
// ============================================================================
// Module   : mem_lane_format
// Purpose  : Combinational byte-lane steering: store replicate/strobe and
//            load lane extract with sign/zero extension.
// Revision : 1.0 - initial release
// ============================================================================
module mem_lane_format
  import mem_bus_responder_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_signed,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [31:0] store_wdata,
  output logic [3:0]  store_wstrb,
  output logic [31:0] load_data
);

  logic [7:0]  w_lane8;
  logic [15:0] w_lane16;

  always_comb begin
    store_wdata = store_data;
    store_wstrb = 4'b1111;
    load_data   = rdata;
    w_lane8     = rdata[{addr_lo, 3'b000} +: 8];
    w_lane16    = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SIZE_BYTE: begin
        store_wdata = {4{store_data[7:0]}};
        store_wstrb = 4'b0001 << addr_lo;
        load_data   = {{24{is_signed & w_lane8[7]}}, w_lane8};
      end
      SIZE_HALF: begin
        store_wdata = {2{store_data[15:0]}};
        store_wstrb = 4'b0011 << {addr_lo[1], 1'b0};
        load_data   = {{16{is_signed & w_lane16[15]}}, w_lane16};
      end
      default: begin
        store_wdata = store_data;
        store_wstrb = 4'b1111;
        load_data   = rdata;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_bus_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_responder
// Purpose  : Turns core load/store strobes into a single valid/ready external
//            bus transaction and formats the returned load data.
//            Optional bus wait limit enabled by defining DBUS_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mem_bus_responder #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_store_data,
  input  logic [1:0]  mem_size,
  input  logic        mem_signed,
  input  logic        mem_load,
  input  logic        mem_store,
  output logic [31:0] mem_load_data,
  output logic        mem_busy,
  output logic        ext_valid,
  output logic        ext_write,
  output logic [31:0] ext_address,
  output logic [31:0] ext_wdata,
  output logic [3:0]  ext_wstrb,
  input  logic        ext_ready,
  input  logic [31:0] ext_rdata,
  output logic        bus_error
);

  import mem_bus_responder_pkg::*;

  state_t      r_state;
  logic [31:0] r_addr;
  logic [31:0] r_store_data;
  logic [1:0]  r_size;
  logic        r_signed;
  logic        r_is_store;
  logic [31:0] r_load_data;

  logic        w_req;
  logic [31:0] w_wdata;
  logic [3:0]  w_wstrb;
  logic [31:0] w_load_fmt;

  assign w_req = mem_load | mem_store;

  mem_lane_format u_lane_format (
    .size        (r_size),
    .is_signed   (r_signed),
    .addr_lo     (r_addr[1:0]),
    .store_data  (r_store_data),
    .rdata       (ext_rdata),
    .store_wdata (w_wdata),
    .store_wstrb (w_wstrb),
    .load_data   (w_load_fmt)
  );

  generate
    if (TIMEOUT_CYCLES < 1) begin : g_tmo_cfg_invalid
      $error("TIMEOUT_CYCLES must be at least 1");
    end
  endgenerate

`ifdef DBUS_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_bus_error;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_addr       <= 32'h0;
      r_store_data <= 32'h0;
      r_size       <= SIZE_BYTE;
      r_signed     <= 1'b0;
      r_is_store   <= 1'b0;
      r_load_data  <= 32'h0;
`ifdef DBUS_TIMEOUT_EN
      r_tmo_cnt    <= '0;
      r_bus_error  <= 1'b0;
`endif
    end else begin
`ifdef DBUS_TIMEOUT_EN
      r_bus_error <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_addr       <= mem_address;
            r_store_data <= mem_store_data;
            r_size       <= mem_size;
            r_signed     <= mem_signed;
            r_is_store   <= mem_store;
            r_state      <= ST_BUS;
`ifdef DBUS_TIMEOUT_EN
            r_tmo_cnt    <= '0;
`endif
          end
        end
        ST_BUS: begin
          // Ready on the limit cycle still completes normally.
          if (ext_ready) begin
            if (!r_is_store) begin
              r_load_data <= w_load_fmt;
            end
            r_state <= ST_DONE;
`ifdef DBUS_TIMEOUT_EN
            r_tmo_cnt <= '0;
          end else if (r_tmo_cnt == TMO_LAST) begin
            r_load_data <= 32'h0;
            r_bus_error <= 1'b1;
            r_tmo_cnt   <= '0;
            r_state     <= ST_DONE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
`endif
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ext_valid     = (r_state == ST_BUS);
  assign ext_write     = ext_valid & r_is_store;
  assign ext_address   = {r_addr[31:2], 2'b00};
  assign ext_wdata     = w_wdata;
  assign ext_wstrb     = ext_write ? w_wstrb : 4'b0000;
  assign mem_load_data = r_load_data;
  // Busy drops together with ext_valid while reset is held.
  assign mem_busy      = rst_n & (ext_valid | ((r_state == ST_IDLE) & w_req));

`ifdef DBUS_TIMEOUT_EN
  assign bus_error = r_bus_error;
`else
  assign bus_error = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_bus_responder
// Purpose  : Scoreboard bench for mem_bus_responder (bus slave model inline).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_bus_responder;

`ifdef DBUS_TIMEOUT_EN
  localparam int TMO     = 4;
  localparam int LHU_DLY = 3;
`else
  localparam int TMO     = 255;
  localparam int LHU_DLY = 5;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] mem_address = 32'h0;
  logic [31:0] mem_store_data = 32'h0;
  logic [1:0]  mem_size = 2'b00;
  logic        mem_signed = 1'b0;
  logic        mem_load = 1'b0;
  logic        mem_store = 1'b0;
  logic [31:0] mem_load_data;
  logic        mem_busy;
  logic        ext_valid;
  logic        ext_write;
  logic [31:0] ext_address;
  logic [31:0] ext_wdata;
  logic [3:0]  ext_wstrb;
  logic        ext_ready = 1'b0;
  logic [31:0] ext_rdata = 32'h0;
  logic        bus_error;

  mem_bus_responder #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_address    (mem_address),
    .mem_store_data (mem_store_data),
    .mem_size       (mem_size),
    .mem_signed     (mem_signed),
    .mem_load       (mem_load),
    .mem_store      (mem_store),
    .mem_load_data  (mem_load_data),
    .mem_busy       (mem_busy),
    .ext_valid      (ext_valid),
    .ext_write      (ext_write),
    .ext_address    (ext_address),
    .ext_wdata      (ext_wdata),
    .ext_wstrb      (ext_wstrb),
    .ext_ready      (ext_ready),
    .ext_rdata      (ext_rdata),
    .bus_error      (bus_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        write;
    logic        is_load;
    logic [31:0] ldata;
  } exp_t;

  exp_t sb_q[$];
  int   n_total = 0;
  int   n_bad   = 0;
  int   n_xact  = 0;
  logic pending = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Monitor: field stability while valid, completion checks in the DONE cycle.
  always @(negedge clk) begin
    exp_t e;
    if (pending) begin
      pending = 1'b0;
      if (sb_q.size() == 0) begin
        check_eq("done_no_expect", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check_eq("done_busy", {31'd0, mem_busy}, 32'd0);
        check_eq("done_valid", {31'd0, ext_valid}, 32'd0);
        check_eq("done_bus_error", {31'd0, bus_error}, 32'd0);
        if (e.is_load) check_eq("load_data", mem_load_data, e.ldata);
      end
    end
    if (ext_valid) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_xact", 32'd1, 32'd0);
      end else begin
        e = sb_q[0];
        check_eq("bus_busy", {31'd0, mem_busy}, 32'd1);
        check_eq("ext_address", ext_address, e.addr);
        check_eq("ext_write", {31'd0, ext_write}, {31'd0, e.write});
        check_eq("ext_wstrb", {28'd0, ext_wstrb}, {28'd0, e.wstrb});
        if (!e.is_load) check_eq("ext_wdata", ext_wdata, e.wdata);
      end
      if (ext_ready) begin
        pending = 1'b1;
        n_xact++;
      end
    end
  end

  // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the next IDLE cycle.
  task automatic do_req(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size,
                        input logic sgn, input logic ld, input logic st,
                        input logic [31:0] rdata, input int dly, input exp_t e);
    mem_address    = addr;
    mem_store_data = data;
    mem_size       = size;
    mem_signed     = sgn;
    mem_load       = ld;
    mem_store      = st;
    sb_q.push_back(e);
    @(negedge clk);
    check_eq("req_busy", {31'd0, mem_busy}, 32'd1);
    check_eq("req_valid", {31'd0, ext_valid}, 32'd0);
    @(posedge clk); #1;
    ext_rdata = ~rdata;
    for (int k = 0; k < dly; k++) begin
      @(posedge clk); #1;
    end
    ext_rdata = rdata;
    ext_ready = 1'b1;
    @(posedge clk); #1;
    ext_ready = 1'b0;
    ext_rdata = 32'h0;
    @(posedge clk); #1;
    mem_load  = 1'b0;
    mem_store = 1'b0;
  endtask

  function automatic exp_t mk(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                              input logic wr, input logic [31:0] ld);
    exp_t e;
    e.addr = a; e.wdata = wd; e.wstrb = ws; e.write = wr; e.is_load = ~wr; e.ldata = ld;
    return e;
  endfunction

  initial begin
    exp_t e;
    int   xact_before;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", {31'd0, ext_valid}, 32'd0);
    check_eq("rst_busy", {31'd0, mem_busy}, 32'd0);
    check_eq("rst_load_data", mem_load_data, 32'd0);
    check_eq("rst_wstrb", {28'd0, ext_wstrb}, 32'd0);
    check_eq("rst_write", {31'd0, ext_write}, 32'd0);
    check_eq("rst_bus_error", {31'd0, bus_error}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // lb signed, same-cycle ready
    do_req(32'h103, 32'h0, 2'b00, 1'b1, 1'b1, 1'b0, 32'h80FF_1234, 0,
           mk(32'h100, 32'h0, 4'b0000, 1'b0, 32'hFFFF_FF80));
    // sh
    do_req(32'h202, 32'h0000_ABCD, 2'b01, 1'b0, 1'b0, 1'b1, 32'h0, 0,
           mk(32'h200, 32'hABCD_ABCD, 4'b1100, 1'b1, 32'h0));
    // lhu with delayed ready
    do_req(32'h2, 32'h0, 2'b01, 1'b0, 1'b1, 1'b0, 32'h8765_4321, LHU_DLY,
           mk(32'h0, 32'h0, 4'b0000, 1'b0, 32'h0000_8765));
    // back-to-back sw then lw
    xact_before = n_xact;
    do_req(32'h10, 32'hDEAD_BEEF, 2'b10, 1'b0, 1'b0, 1'b1, 32'h0, 1,
           mk(32'h10, 32'hDEAD_BEEF, 4'b1111, 1'b1, 32'h0));
    do_req(32'h10, 32'h0, 2'b10, 1'b0, 1'b1, 1'b0, 32'h1234_5678, 0,
           mk(32'h10, 32'h0, 4'b0000, 1'b0, 32'h1234_5678));
    check_eq("b2b_xact_count", n_xact - xact_before, 32'd2);
    // sb, lh signed, lbu, load+store collision
    do_req(32'h31, 32'h0000_005A, 2'b00, 1'b0, 1'b0, 1'b1, 32'h0, 0,
           mk(32'h30, 32'h5A5A_5A5A, 4'b0010, 1'b1, 32'h0));
    do_req(32'h6, 32'h0, 2'b01, 1'b1, 1'b1, 1'b0, 32'h8001_7FFF, 2,
           mk(32'h4, 32'h0, 4'b0000, 1'b0, 32'hFFFF_8001));
    do_req(32'h1, 32'h0, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0000_C300, 0,
           mk(32'h0, 32'h0, 4'b0000, 1'b0, 32'h0000_00C3));
    do_req(32'h8, 32'h1122_3344, 2'b10, 1'b0, 1'b1, 1'b1, 32'h0, 0,
           mk(32'h8, 32'h1122_3344, 4'b1111, 1'b1, 32'h0));

    // Reset in the middle of a bus wait
    mem_address = 32'h40; mem_size = 2'b10; mem_signed = 1'b0; mem_load = 1'b1;
    sb_q.push_back(mk(32'h40, 32'h0, 4'b0000, 1'b0, 32'h0));
    @(posedge clk); @(posedge clk); #3;
    check_eq("pre_rst_valid", {31'd0, ext_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_valid", {31'd0, ext_valid}, 32'd0);
    check_eq("midrst_busy", {31'd0, mem_busy}, 32'd0);
    check_eq("midrst_bus_error", {31'd0, bus_error}, 32'd0);
    check_eq("midrst_load_data", mem_load_data, 32'd0);
    mem_load = 1'b0;
    void'(sb_q.pop_front());
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("postrst_valid", {31'd0, ext_valid}, 32'd0);
    check_eq("postrst_busy", {31'd0, mem_busy}, 32'd0);

    // Reload a known value so a later zeroing is observable
    do_req(32'h20, 32'h0, 2'b10, 1'b0, 1'b1, 1'b0, 32'hCAFE_F00D, 0,
           mk(32'h20, 32'h0, 4'b0000, 1'b0, 32'hCAFE_F00D));
    check_eq("hold_load_data", mem_load_data, 32'hCAFE_F00D);

`ifdef DBUS_TIMEOUT_EN
    // Ready on the limit cycle completes normally
    do_req(32'h24, 32'h0, 2'b10, 1'b0, 1'b1, 1'b0, 32'h0BAD_CAFE, TMO - 1,
           mk(32'h24, 32'h0, 4'b0000, 1'b0, 32'h0BAD_CAFE));
    // No ready at all: timeout
    mem_address = 32'h44; mem_size = 2'b10; mem_load = 1'b1;
    sb_q.push_back(mk(32'h44, 32'h0, 4'b0000, 1'b0, 32'h0));
    repeat (TMO) @(posedge clk);
    @(negedge clk);
    check_eq("tmo_last_valid", {31'd0, ext_valid}, 32'd1);
    check_eq("tmo_last_err", {31'd0, bus_error}, 32'd0);
    @(posedge clk); #1;
    void'(sb_q.pop_front());
    check_eq("tmo_valid", {31'd0, ext_valid}, 32'd0);
    check_eq("tmo_bus_error", {31'd0, bus_error}, 32'd1);
    check_eq("tmo_load_data", mem_load_data, 32'd0);
    check_eq("tmo_busy", {31'd0, mem_busy}, 32'd0);
    @(posedge clk); #1;
    mem_load = 1'b0;
    check_eq("tmo_err_pulse", {31'd0, bus_error}, 32'd0);
`endif

    repeat (3) @(posedge clk);
    check_eq("sb_empty", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
